// File: rtl/rr_bank_arbiter.sv
// Round-robin arbiter with lock-hold, owning a shared BITS-wide result register bank.
// A granted requester that still asserts req writes its wdata slice into the bank one edge later.

module rr_bank_bit (
    input  logic clk,
    input  logic reset,
    input  logic we,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= 1'b0;
        else if (we)
            q <= d;
    end
endmodule

module rr_bank_arbiter #(
    parameter int BITS = 4,
    parameter int N    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        lock,
    input  logic [N*BITS-1:0]   wdata,
    output logic [N-1:0]        grant,
    output logic [BITS-1:0]     result,
    output logic                valid,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]   ptr, nxt_ptr, sel;
    logic [N-1:0]    nxt_grant;
    logic            hold, we;
    logic [BITS-1:0] wsel;

    // Lock only counts for the current holder, and only while it still requests.
    assign hold  = |(grant & req & lock);
    assign we    = |(grant & req);
    assign owner = ptr;

    always_comb begin
        wsel = '0;
        for (int k = 0; k < N; k++)
            if (grant[k])
                wsel = wsel | wdata[k*BITS +: BITS];
    end

    // Scan from farthest to nearest so the last match is the first requester after ptr.
    always_comb begin
        nxt_grant = '0;
        nxt_ptr   = ptr;
        sel       = '0;
        if (hold) begin
            nxt_grant = grant;
        end else begin
            for (int i = N; i >= 1; i--) begin
                sel = PW'((int'(ptr) + i) % N);
                if (req[sel]) begin
                    nxt_grant      = '0;
                    nxt_grant[sel] = 1'b1;
                    nxt_ptr        = sel;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant <= '0;
            ptr   <= PW'(N - 1);
            valid <= 1'b0;
        end else begin
            grant <= nxt_grant;
            ptr   <= nxt_ptr;
            if (we)
                valid <= 1'b1;
        end
    end

    for (genvar b = 0; b < BITS; b++) begin : g_bit
        rr_bank_bit u_bit (
            .clk   (clk),
            .reset (reset),
            .we    (we),
            .d     (wsel[b]),
            .q     (result[b])
        );
    end
endmodule

// File: tb/tb_rr_bank_arbiter.sv
// Bench for rr_bank_arbiter: directed vector table, reset-mid-lock sequence, and random traffic
// checked against a behavioural arbiter model plus a starvation monitor.

module tb_rr_bank_arbiter;
    localparam int N    = 4;
    localparam int BITS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req, lock;
    logic [N*BITS-1:0] wdata;
    logic [N-1:0]      grant;
    logic [BITS-1:0]   result;
    logic              valid;
    logic [1:0]        owner;

    int n_pass = 0;
    int n_tot  = 0;

    // behavioural model state: index of holder (-1 none), last granted index, bank contents
    int              m_gnt;
    int              m_ptr;
    logic [BITS-1:0] m_res;
    logic            m_val;

    rr_bank_arbiter #(.BITS(BITS), .N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .grant  (grant),
        .result (result),
        .valid  (valid),
        .owner  (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                              input logic [N*BITS-1:0] wd);
        int nw;
        if (rst) begin
            m_gnt = -1;
            m_ptr = N - 1;
            m_res = '0;
            m_val = 1'b0;
        end else begin
            if (m_gnt >= 0 && r[m_gnt]) begin
                m_res = wd[m_gnt*BITS +: BITS];
                m_val = 1'b1;
            end
            if (!(m_gnt >= 0 && r[m_gnt] && l[m_gnt])) begin
                nw = -1;
                for (int i = 1; i <= N; i++) begin
                    if (nw < 0 && r[(m_ptr + i) % N])
                        nw = (m_ptr + i) % N;
                end
                m_gnt = nw;
                if (nw >= 0)
                    m_ptr = nw;
            end
        end
    endtask

    // drive inputs, cross one rising edge, advance the model, then settle for sampling
    task automatic cycle(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                         input logic [N*BITS-1:0] wd);
        reset = rst;
        req   = r;
        lock  = l;
        wdata = wd;
        @(posedge clk);
        model_step(rst, r, l, wd);
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [N-1:0] eg;
        eg = (m_gnt < 0) ? '0 : (N'(1) << m_gnt);
        chk({tag, " grant"},  32'(grant),  32'(eg));
        chk({tag, " result"}, 32'(result), 32'(m_res));
        chk({tag, " valid"},  32'(valid),  32'(m_val));
        chk({tag, " owner"},  32'(owner),  32'(m_ptr));
    endtask

    typedef struct {
        logic              rst;
        logic [N-1:0]      req;
        logic [N-1:0]      lock;
        logic [N*BITS-1:0] wd;
        logic [N-1:0]      g;
        logic [BITS-1:0]   res;
        logic              v;
        logic [1:0]        own;
    } vec_t;

    vec_t tbl[19];
    int   wc[N];
    int   max_wait;

    initial begin
        reset = 1'b1; req = '0; lock = '0; wdata = '0;

        //             rst   req      lock     wdata     grant    res    v     own
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 16'hDCBA, 4'b0000, 4'h0, 1'b0, 2'd3};
        tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 16'hDCBA, 4'b0001, 4'h0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 16'hDCBA, 4'b0001, 4'hA, 1'b1, 2'd0};
        tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 16'hDCBA, 4'b0010, 4'hA, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 16'hDCBA, 4'b0100, 4'hB, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 16'hDCBA, 4'b1000, 4'hC, 1'b1, 2'd3};
        tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 16'hDCBA, 4'b0001, 4'hD, 1'b1, 2'd0};
        tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 16'hDCBA, 4'b0010, 4'hA, 1'b1, 2'd1};
        tbl[8]  = '{1'b0, 4'b0110, 4'b0010, 16'hDCBA, 4'b0010, 4'hB, 1'b1, 2'd1};
        tbl[9]  = '{1'b0, 4'b0110, 4'b0010, 16'hDCBA, 4'b0010, 4'hB, 1'b1, 2'd1};
        tbl[10] = '{1'b0, 4'b0110, 4'b0010, 16'hDCBA, 4'b0010, 4'hB, 1'b1, 2'd1};
        tbl[11] = '{1'b0, 4'b0110, 4'b0000, 16'h9876, 4'b0100, 4'h7, 1'b1, 2'd2};
        tbl[12] = '{1'b0, 4'b0000, 4'b0000, 16'h9876, 4'b0000, 4'h7, 1'b1, 2'd2};
        tbl[13] = '{1'b0, 4'b0100, 4'b0000, 16'h9876, 4'b0100, 4'h7, 1'b1, 2'd2};
        tbl[14] = '{1'b1, 4'b0100, 4'b0000, 16'h9876, 4'b0000, 4'h0, 1'b0, 2'd3};
        tbl[15] = '{1'b0, 4'b1001, 4'b0000, 16'h5432, 4'b0001, 4'h0, 1'b0, 2'd0};
        tbl[16] = '{1'b0, 4'b1001, 4'b0000, 16'h5432, 4'b1000, 4'h2, 1'b1, 2'd3};
        tbl[17] = '{1'b0, 4'b1001, 4'b0001, 16'h5432, 4'b0001, 4'h5, 1'b1, 2'd0};
        tbl[18] = '{1'b0, 4'b0000, 4'b0001, 16'h5432, 4'b0000, 4'h5, 1'b1, 2'd0};

        for (int v = 0; v < 19; v++) begin
            cycle(tbl[v].rst, tbl[v].req, tbl[v].lock, tbl[v].wd);
            chk($sformatf("vec%0d grant", v),  32'(grant),  32'(tbl[v].g));
            chk($sformatf("vec%0d result", v), 32'(result), 32'(tbl[v].res));
            chk($sformatf("vec%0d valid", v),  32'(valid),  32'(tbl[v].v));
            chk($sformatf("vec%0d owner", v),  32'(owner),  32'(tbl[v].own));
        end

        // reset arriving mid-lock must drop the hold and restart from requester 0's turn
        cycle(1'b0, 4'b0010, 4'b0010, 16'h1111);
        cycle(1'b0, 4'b0010, 4'b0010, 16'h2222);
        chk("lockseq held grant", 32'(grant), 32'h2);
        cycle(1'b1, 4'b0010, 4'b0010, 16'h3333);
        chk("lockseq reset grant", 32'(grant), 32'h0);
        chk("lockseq reset result", 32'(result), 32'h0);
        cycle(1'b0, 4'b1100, 4'b1100, 16'hF0E0);
        chk("lockseq restart grant", 32'(grant), 32'h4);
        chk("lockseq restart owner", 32'(owner), 32'd2);
        cycle(1'b0, 4'b1100, 4'b1100, 16'hF0E0);
        chk_model("lockseq model");
        chk("lockseq result", 32'(result), 32'h0);

        // random traffic with lock and occasional reset, checked every cycle against the model
        for (int c = 0; c < 4000; c++) begin
            cycle(($urandom_range(0, 199) == 0), N'($urandom), N'($urandom & $urandom),
                  (N*BITS)'($urandom));
            chk_model("rand");
            chk("rand onehot", 32'($countones(grant) <= 1), 32'd1);
        end

        // lock-free traffic: no continuous requester waits through more than N foreign grants
        for (int k = 0; k < N; k++) wc[k] = 0;
        max_wait = 0;
        for (int c = 0; c < 2000; c++) begin
            cycle(1'b0, N'($urandom | $urandom), '0, (N*BITS)'($urandom));
            chk_model("fair");
            for (int k = 0; k < N; k++) begin
                if (grant[k] || !req[k])
                    wc[k] = 0;
                else if (grant != '0)
                    wc[k]++;
                if (wc[k] > max_wait)
                    max_wait = wc[k];
            end
        end
        chk("fair max wait within N", 32'(max_wait <= N), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
